// File: rtl/timer_seq_pkg.sv
// timer_seq_pkg
//   Shared definitions for the timer APB sequencer: timer register map,
//   TCR/TSR bit positions, sequencer FSM states and completion status codes.
//   tcr_value() builds a TCR byte from its individual fields.
package timer_seq_pkg;

  localparam logic [7:0] TDR_ADDR = 8'h00;
  localparam logic [7:0] TCR_ADDR = 8'h01;
  localparam logic [7:0] TSR_ADDR = 8'h02;

  localparam int LOAD_BIT = 7;
  localparam int DW_BIT   = 5;
  localparam int EN_BIT   = 4;
  localparam int CKS_LSB  = 0;
  localparam int UDF_BIT  = 1;
  localparam int OVF_BIT  = 0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_TDR,
    S_W_LOAD,
    S_W_RUN,
    S_GAP,
    S_R_TSR,
    S_W_CLR,
    S_W_STOP,
    S_DONE
  } state_e;

  localparam logic [1:0] ST_OK     = 2'b00;
  localparam logic [1:0] ST_FLAG   = 2'b01;
  localparam logic [1:0] ST_TMO    = 2'b10;
  localparam logic [1:0] ST_SLVERR = 2'b11;

  function automatic logic [7:0] tcr_value(input logic load, input logic dw,
                                           input logic en, input logic [1:0] cks);
    logic [7:0] v;
    v              = 8'h00;
    v[LOAD_BIT]    = load;
    v[DW_BIT]      = dw;
    v[EN_BIT]      = en;
    v[CKS_LSB +: 2] = cks;
    return v;
  endfunction

endpackage

// File: rtl/timer_apb_sequencer_xfer.sv
// apb_master_xfer
//   Single APB master transfer engine. A one-cycle start pulse latches
//   addr/wdata/write and makes the next cycle the setup cycle; access cycles
//   follow until pready. done/rdata/err are valid in the completing cycle.
//   A start in the completing cycle chains straight into the next setup.
// Ports:
//   pclk, preset                  clock, synchronous active-high reset
//   start, addr, wdata, write     transfer request
//   done, rdata, err              completion, read data, slave error
//   psel, penable, pwrite, paddr, pwdata, prdata, pready, pslverr   APB bus
module apb_master_xfer
  import timer_seq_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              write,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;

  assign done  = psel_q & penable_q & pready;
  assign rdata = prdata;
  assign err   = done & pslverr;

  always_comb begin
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    if (start) begin
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = write;
      paddr_d   = addr;
      pwdata_d  = wdata;
    end else if (psel_q && !penable_q) begin
      penable_d = 1'b1;
    end else if (done) begin
      psel_d    = 1'b0;
      penable_d = 1'b0;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;

endmodule

// File: rtl/timer_apb_sequencer.sv
// timer_apb_sequencer
//   Runs one full count session on the 8-bit timer per command: load TDR,
//   load then start the counter via TCR, poll TSR for the expected flag,
//   clear the flag, stop the timer and report a status.
//   Optional feature macro TIMER_SEQ_AUTOCLR_EN: when defined the flag is
//   cleared (TSR <= 00) before stopping; otherwise TSR is left set.
// Command handshake: a command is accepted on a rising edge where
//   cmd_valid && cmd_ready; cmd_ready is high only in IDLE, all cmd_* fields
//   are latched then and ignored afterwards. Completion is a one-cycle
//   done_valid pulse; done_status/done_tsr hold until the next completion.
// Ports:
//   pclk, preset                     clock, synchronous active-high reset
//   cmd_valid/ready, cmd_tdr, cmd_dw, cmd_cks, cmd_timeout   command
//   done_valid, done_status, done_tsr                         completion
//   psel, penable, pwrite, paddr, pwdata, prdata, pready, pslverr  APB master
//   dbg_state                        current FSM state
module timer_apb_sequencer
  import timer_seq_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int POLL_GAP = 4,
  parameter int TMO_W    = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_tdr,
  input  logic              cmd_dw,
  input  logic [1:0]        cmd_cks,
  input  logic [TMO_W-1:0]  cmd_timeout,
  output logic              done_valid,
  output logic [1:0]        done_status,
  output logic [7:0]        done_tsr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  output state_e            dbg_state
);

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

`ifdef TIMER_SEQ_AUTOCLR_EN
  localparam state_e FLAG_NEXT = S_W_CLR;
`else
  localparam state_e FLAG_NEXT = S_W_STOP;
`endif

  state_e             state_q, state_d;
  logic [7:0]         tdr_q, tdr_d;
  logic               dw_q, dw_d;
  logic [1:0]         cks_q, cks_d;
  logic [TMO_W-1:0]   timeout_q, timeout_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [1:0]         status_q, status_d;
  logic [7:0]         tsr_q, tsr_d;
  logic [1:0]         done_status_q, done_status_d;
  logic [7:0]         done_tsr_q, done_tsr_d;

  logic               xfer_start, xfer_write, xfer_done, xfer_err;
  logic [ADDR_W-1:0]  xfer_addr;
  logic [DATA_W-1:0]  xfer_wdata, xfer_rdata;
  logic               tmo_expired, flag_exp, flag_other;
  logic [7:0]         rd_tsr;

  assign rd_tsr      = xfer_rdata[7:0];
  assign flag_exp    = dw_q ? rd_tsr[UDF_BIT] : rd_tsr[OVF_BIT];
  assign flag_other  = dw_q ? rd_tsr[OVF_BIT] : rd_tsr[UDF_BIT];
  assign tmo_expired = (timeout_q != '0) && (tmo_cnt_q >= timeout_q);

  // Next state, command latch and session bookkeeping.
  always_comb begin
    state_d       = state_q;
    tdr_d         = tdr_q;
    dw_d          = dw_q;
    cks_d         = cks_q;
    timeout_d     = timeout_q;
    status_d      = status_q;
    tsr_d         = tsr_q;
    done_status_d = done_status_q;
    done_tsr_d    = done_tsr_q;
    gap_cnt_d     = '0;
    // Free-running saturating counter, re-zeroed when the timer starts.
    if (state_q == S_W_RUN && xfer_done) tmo_cnt_d = '0;
    else if (tmo_cnt_q != '1)            tmo_cnt_d = tmo_cnt_q + 1'b1;
    else                                 tmo_cnt_d = tmo_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          tdr_d     = cmd_tdr;
          dw_d      = cmd_dw;
          cks_d     = cmd_cks;
          timeout_d = cmd_timeout;
          status_d  = ST_OK;
          tsr_d     = 8'h00;
          state_d   = S_W_TDR;
        end
      end
      S_W_TDR, S_W_LOAD, S_W_RUN, S_R_TSR, S_W_CLR: begin
        if (xfer_done) begin
          if (xfer_err) begin
            status_d = ST_SLVERR;
            state_d  = S_W_STOP;
          end else begin
            case (state_q)
              S_W_TDR:  state_d = S_W_LOAD;
              S_W_LOAD: state_d = S_W_RUN;
              S_W_RUN:  state_d = S_GAP;
              S_W_CLR:  state_d = S_W_STOP;
              S_R_TSR: begin
                tsr_d = rd_tsr;
                // Flags win over the timeout when both apply.
                if (flag_exp) begin
                  status_d = ST_OK;
                  state_d  = FLAG_NEXT;
                end else if (flag_other) begin
                  status_d = ST_FLAG;
                  state_d  = FLAG_NEXT;
                end else if (tmo_expired) begin
                  status_d = ST_TMO;
                  state_d  = S_W_STOP;
                end else begin
                  state_d  = S_GAP;
                end
              end
              default: state_d = S_IDLE;
            endcase
          end
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_cnt_q == GAP_LAST) state_d = S_R_TSR;
      end
      S_W_STOP: begin
        if (xfer_done) begin
          if (xfer_err) status_d = ST_SLVERR;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DONE) begin
      done_status_d = status_d;
      done_tsr_d    = tsr_d;
    end
  end

  // A transfer is launched on the edge that enters a transfer state, so the
  // setup cycle is the first cycle spent in that state.
  always_comb begin
    xfer_start = 1'b0;
    xfer_addr  = '0;
    xfer_wdata = '0;
    xfer_write = 1'b0;
    if (state_d != state_q) begin
      case (state_d)
        S_W_TDR: begin
          xfer_start = 1'b1;
          xfer_write = 1'b1;
          xfer_addr  = ADDR_W'(TDR_ADDR);
          xfer_wdata = DATA_W'(tdr_d);
        end
        S_W_LOAD: begin
          xfer_start = 1'b1;
          xfer_write = 1'b1;
          xfer_addr  = ADDR_W'(TCR_ADDR);
          xfer_wdata = DATA_W'(tcr_value(1'b1, dw_d, 1'b0, cks_d));
        end
        S_W_RUN: begin
          xfer_start = 1'b1;
          xfer_write = 1'b1;
          xfer_addr  = ADDR_W'(TCR_ADDR);
          xfer_wdata = DATA_W'(tcr_value(1'b0, dw_d, 1'b1, cks_d));
        end
        S_R_TSR: begin
          xfer_start = 1'b1;
          xfer_addr  = ADDR_W'(TSR_ADDR);
        end
        S_W_CLR: begin
          xfer_start = 1'b1;
          xfer_write = 1'b1;
          xfer_addr  = ADDR_W'(TSR_ADDR);
        end
        S_W_STOP: begin
          xfer_start = 1'b1;
          xfer_write = 1'b1;
          xfer_addr  = ADDR_W'(TCR_ADDR);
          xfer_wdata = DATA_W'(tcr_value(1'b0, dw_d, 1'b0, cks_d));
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q       <= S_IDLE;
      tdr_q         <= 8'h00;
      dw_q          <= 1'b0;
      cks_q         <= 2'b00;
      timeout_q     <= '0;
      tmo_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      status_q      <= ST_OK;
      tsr_q         <= 8'h00;
      done_status_q <= ST_OK;
      done_tsr_q    <= 8'h00;
    end else begin
      state_q       <= state_d;
      tdr_q         <= tdr_d;
      dw_q          <= dw_d;
      cks_q         <= cks_d;
      timeout_q     <= timeout_d;
      tmo_cnt_q     <= tmo_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      status_q      <= status_d;
      tsr_q         <= tsr_d;
      done_status_q <= done_status_d;
      done_tsr_q    <= done_tsr_d;
    end
  end

  apb_master_xfer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_xfer (
    .pclk    (pclk),
    .preset  (preset),
    .start   (xfer_start),
    .addr    (xfer_addr),
    .wdata   (xfer_wdata),
    .write   (xfer_write),
    .done    (xfer_done),
    .rdata   (xfer_rdata),
    .err     (xfer_err),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

  assign cmd_ready   = (state_q == S_IDLE);
  assign done_valid  = (state_q == S_DONE);
  assign done_status = done_status_q;
  assign done_tsr    = done_tsr_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/timer_apb_sequencer.md
# timer_apb_sequencer

APB master controller that runs one complete count session on the 8-bit timer IP for a single command. It loads TDR, loads and starts the counter through TCR, polls TSR for the expected overflow or underflow flag, clears the flag, stops the timer, and reports a status. It sits between a command source (CPU model, test sequencer, or system FSM) and the timer's APB slave port, and it replaces hand-written write/read sequences.

## Interface
- ADDR_W, 8, APB address width
- DATA_W, 8, APB data width
- POLL_GAP, 4, idle pclk cycles between consecutive TSR reads (≥1)
- TMO_W, 16, width of the timeout counter and of cmd_timeout

Reset is synchronous and active-high.
- pclk  in  1  single clock; all state changes on rising edge
- preset  in  1  synchronous reset, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_tdr  in  8  reload value written to TDR
- cmd_dw  in  1  1 = count down (expect UDF), 0 = count up (expect OVF)
- cmd_cks  in  2  clock select written to TCR[1:0]
- cmd_timeout  in  TMO_W  pclk budget after start; 0 = unlimited
- done_valid  out  1  one-cycle completion pulse
- done_status  out  2  00 ok, 01 wrong flag, 10 timeout, 11 slave error
- done_tsr  out  8  last TSR value read (00 if none was read)
- psel, penable, pwrite  out  1  APB master controls
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready, pslverr  in  1  APB completion and error

## Operation
- Register map: TDR 0x00; TCR 0x01 = {load[7], 0, dw[5], en[4], 00, cks[1:0]}; TSR 0x02 = {…, udf[1], ovf[0]}. Writing 0x00 to TSR clears it.
- FSM: IDLE → W_TDR (0x00←tdr) → W_LOAD (0x01←{1,0,dw,0,00,cks}) → W_RUN (0x01←{0,0,dw,1,00,cks}) → GAP → R_TSR → decision.
- Decision: expected flag set → W_CLR (0x02←00) → W_STOP (0x01←{0,0,dw,0,00,cks}) → DONE, status 00.
- Decision: only the other flag set → W_CLR → W_STOP → DONE, status 01.
- Decision: no flag and the timeout has expired → W_STOP → DONE, status 10.
- Decision: otherwise → GAP.
- Flag check has priority over timeout when both apply at the same decision.
- The timeout counter clears at W_RUN completion, increments every cycle and saturates. It expires when cmd_timeout≠0 and count ≥ cmd_timeout.
- The command is latched on the cmd_valid && cmd_ready handshake. Inputs are ignored afterwards.
- pslverr on any completed transfer except W_STOP → W_STOP → DONE, status 11.
- pslverr on W_STOP → DONE, status 11.

## Timing
- Reset values: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, done_valid=0, done_status=00, done_tsr=00, state IDLE, cmd_ready=1.
- Each transfer has a setup cycle (psel=1, penable=0) followed by access cycles (psel=1, penable=1) until pready=1. The minimum is 2 cycles.
- paddr, pwdata and pwrite are stable from setup through completion.
- Setup of the next transfer starts the cycle after completion. psel drops only in GAP or DONE.
- First setup cycle is the cycle after the handshake.
- GAP lasts exactly POLL_GAP cycles with psel=0.
- prdata is sampled in the completing cycle of R_TSR.
- done_valid is high for exactly one cycle in DONE, with done_status and done_tsr valid and held until the next done. cmd_ready returns the next cycle.
- preset asserted mid-session: on the next edge all outputs return to reset values, the command is dropped and no done pulse is produced.

## Configuration
- TIMER_SEQ_AUTOCLR_EN defined: W_CLR is performed as described.
- Not defined: W_CLR is skipped, the decision branches directly to W_STOP, and TSR is left set for software.

## Structure
- Shared package timer_seq_pkg holds:
  - address constants TDR_ADDR, TCR_ADDR, TSR_ADDR
  - TCR bit positions (LOAD_BIT, DW_BIT, EN_BIT, CKS_LSB) and TSR bits UDF_BIT, OVF_BIT
  - the state enum
  - status codes ST_OK, ST_FLAG, ST_TMO, ST_SLVERR
- One sub-module, apb_master_xfer, owns the setup/access handshake: start, addr, wdata, write → done, rdata, err.

## Test plan
- cmd_tdr=FF, dw=1, cks=10, timeout=0, pready=1 → writes (00,FF), (01,A2), (01,32); TSR polls read 00 until ~2048 pclk, then 02; then (02,00), (01,22); done_status=00, done_tsr=02.
- Same command, cmd_timeout=100 → no flag within 100 cycles; (01,22) written, no TSR clear; done_status=10, done_tsr=00.
- dw=1 with the slave model returning TSR=01 → (02,00), (01,22); done_status=01, done_tsr=01.
- Slave holds pready=0 for 3 access cycles on W_LOAD → penable held 4 cycles, paddr=01 and pwdata=A2 stable; session completes with status 00.
- pslverr=1 on W_TDR → next transfer is (01,{0,0,dw,0,00,cks}); done_status=11.
- preset asserted during GAP → psel=0 and cmd_ready=1 the next cycle, no done_valid; a new command then runs normally.
- With TIMER_SEQ_AUTOCLR_EN undefined, rerun the first scenario → no write to 0x02; done_tsr=02.
